uart_tx_core: RTL and testbench

UART transmitter for the low-power multi-clock communication system: the transmit-side counterpart of the UART RX path. Accepts a parallel word via a valid/busy handshake, then serializes it LSB-first as start bit, data bits, optional parity bit and stop bit on a single line. Each bit is held for a programmable number of clock cycles. Sits between the system controller's TX data path and the UART pad.

---
 rtl/uart_tx_pkg.sv | 19 +
 rtl/uart_tx_bit_timer.sv | 50 +++++
 rtl/uart_tx_core.sv | 145 ++++++++++++++
 tb/tb_uart_tx_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit path.
// Holds the FSM state enum, parity selectors and default widths.
package uart_tx_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_PRESCALE_WIDTH = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit period counter and data bit index counter for the UART TX FSM.
// Ports: clk, rst (async high), run, in_data, period (>=1);
//        bit_done, bit_almost, last_data_bit.
module uart_tx_bit_timer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      in_data,
  input  logic [PRESCALE_WIDTH-1:0] period,
  output logic                      bit_done,
  output logic                      bit_almost,
  output logic                      last_data_bit
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [IW-1:0]             idx;

  // bit_almost flags the cycle before bit_done so the FSM can
  // drop its registered BUSY exactly in the final bit cycle.
  assign bit_done      = run && (cnt == period - ONE);
  assign bit_almost    = run && (period != ONE) &&
                         (cnt == period - TWO);
  assign last_data_bit = (idx == IW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (!run || bit_done)
        cnt <= '0;
      else
        cnt <= cnt + ONE;

      if (!in_data)
        idx <= '0;
      else if (bit_done)
        idx <= last_data_bit ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: start, LSB-first data, optional parity, stop.
// Ports: CLK, RST, P_DATA, DATA_VALID, PAR_EN, PAR_TYP, PRESCALE;
//        TX_OUT (idle high), BUSY.
module uart_tx_core
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = DEF_PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY
);

  tx_state_t                 state;
  logic [DATA_WIDTH-1:0]     shreg;
  logic                      par_en_q;
  logic                      par_bit_q;
  logic [PRESCALE_WIDTH-1:0] period_q;

  logic bit_done;
  logic bit_almost;
  logic last_data_bit;
  logic accept;
  logic shift_en;
  logic stop_busy;

  uart_tx_bit_timer #(
    .DATA_WIDTH    (DATA_WIDTH),
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_timer (
    .clk          (CLK),
    .rst          (RST),
    .run          (state != IDLE),
    .in_data      (state == DATA),
    .period       (period_q),
    .bit_done     (bit_done),
    .bit_almost   (bit_almost),
    .last_data_bit(last_data_bit)
  );

  assign accept = DATA_VALID && !BUSY &&
                  ((state == IDLE) ||
                   ((state == STOP) && bit_done));

  // The shift register always presents the next data bit on bit 0,
  // so the FSM loads it into TX_OUT at each bit boundary.
  assign shift_en = bit_done &&
                    ((state == START) ||
                     ((state == DATA) && !last_data_bit));

  // With a one-cycle bit period the whole STOP bit is its last cycle.
  assign stop_busy = (period_q != PRESCALE_WIDTH'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      period_q  <= PRESCALE_WIDTH'(1);
    end else if (accept) begin
      shreg     <= P_DATA;
      par_en_q  <= PAR_EN;
      par_bit_q <= (PAR_TYP == PAR_ODD) ? ~(^P_DATA) : ^P_DATA;
      period_q  <= (PRESCALE == '0) ? PRESCALE_WIDTH'(1)
                                    : PRESCALE;
    end else if (shift_en) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      TX_OUT <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
          if (accept) begin
            state  <= START;
            TX_OUT <= 1'b0;
            BUSY   <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            TX_OUT <= shreg[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (!last_data_bit) begin
              TX_OUT <= shreg[0];
            end else if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit_q;
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
              BUSY   <= stop_busy;
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
            BUSY   <= stop_busy;
          end
        end
        STOP: begin
          if (bit_done) begin
            if (accept) begin
              state  <= START;
              TX_OUT <= 1'b0;
              BUSY   <= 1'b1;
            end else begin
              state  <= IDLE;
              TX_OUT <= 1'b1;
              BUSY   <= 1'b0;
            end
          end else if (bit_almost) begin
            BUSY <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core.
// Cycle-level frame model plus table-driven and corner-case sequences.
module tb_uart_tx_core;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] PRESCALE = 6'd1;
  logic       TX_OUT;
  logic       BUSY;

  uart_tx_core #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .PRESCALE  (PRESCALE),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic tx;
    logic busy;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pen;
    logic       pt;
    logic [5:0] ps;
    logic       par;
    int         len;
  } vec_t;

  exp_t q[$];
  logic cur_busy = 1'b0;
  logic chk = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic tr_tx [0:511];
  logic tr_bz [0:511];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Expected line: one entry per clock cycle of the frame.
  function automatic void push_frame(input logic [7:0] d,
                                     input logic pen, input logic pt,
                                     input logic [5:0] ps);
    int p;
    logic bits[$];
    exp_t e;
    p = (ps == 0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back((^d) ^ pt);
    bits.push_back(1'b1);
    foreach (bits[b])
      for (int k = 0; k < p; k++) begin
        e.tx = bits[b];
        e.busy = 1'b1;
        q.push_back(e);
      end
    e = q[q.size()-1];
    e.busy = 1'b0;
    q[q.size()-1] = e;
  endfunction

  task automatic tick();
    exp_t e;
    if (chk && DATA_VALID && !cur_busy)
      push_frame(P_DATA, PAR_EN, PAR_TYP, PRESCALE);
    @(posedge CLK);
    @(negedge CLK);
    if (q.size() > 0) e = q.pop_front();
    else begin
      e.tx = 1'b1;
      e.busy = 1'b0;
    end
    cur_busy = e.busy;
    if (chk) check("line", {30'd0, TX_OUT, BUSY}, {30'd0, e.tx, e.busy});
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pen,
                           input logic pt, input logic [5:0] ps,
                           output int len);
    int n;
    P_DATA = d;
    PAR_EN = pen;
    PAR_TYP = pt;
    PRESCALE = ps;
    DATA_VALID = 1'b1;
    tick();
    check("start_latency", {30'd0, TX_OUT, BUSY}, 32'd1);
    DATA_VALID = 1'b0;
    P_DATA = ~d;
    PAR_EN = ~pen;
    PAR_TYP = ~pt;
    PRESCALE = ps + 6'd3;
    tr_tx[0] = TX_OUT;
    tr_bz[0] = BUSY;
    n = 1;
    while (BUSY && n < 400) begin
      tick();
      tr_tx[n] = TX_OUT;
      tr_bz[n] = BUSY;
      n++;
    end
    len = n;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int len, len0, p;
    logic [15:0] w0, w1, wb;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 6'd1, 1'b0, 10};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 6'd4, 1'b1, 44};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 6'd3, 1'b1, 33};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 6'd3, 1'b0, 33};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 6'd0, 1'b1, 11};
    vecs[5] = '{8'h3C, 1'b0, 1'b1, 6'd2, 1'b0, 20};

    @(negedge CLK);
    @(negedge CLK);
    check("reset_tx", {31'd0, TX_OUT}, 32'd1);
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;
    chk = 1'b1;
    tick();

    // Table-driven frames.
    foreach (vecs[i]) begin
      run_frame(vecs[i].d, vecs[i].pen, vecs[i].pt, vecs[i].ps, len);
      p = (vecs[i].ps == 0) ? 1 : int'(vecs[i].ps);
      check("frame_len", len, vecs[i].len);
      if (vecs[i].pen)
        check("parity_bit", {31'd0, tr_tx[9*p]}, {31'd0, vecs[i].par});
      check("stop_bit", {31'd0, tr_tx[len-1]}, 32'd1);
      if (i == 0) begin
        w0 = '0;
        wb = '0;
        for (int k = 0; k < 10; k++) begin
          w0[k] = tr_tx[k];
          wb[k] = tr_bz[k];
        end
        check("a5_line", {16'd0, w0}, 32'h034A);
        check("a5_busy", {16'd0, wb}, 32'h01FF);
      end
    end
    DATA_VALID = 1'b0;
    tick();
    tick();

    // PRESCALE=0 must look exactly like PRESCALE=1.
    run_frame(8'h6B, 1'b1, 1'b0, 6'd0, len0);
    w0 = '0;
    for (int k = 0; k < 11; k++) w0[k] = tr_tx[k];
    tick();
    run_frame(8'h6B, 1'b1, 1'b0, 6'd1, len);
    w1 = '0;
    for (int k = 0; k < 11; k++) w1[k] = tr_tx[k];
    check("p0_len", len0, len);
    check("p0_wave", {16'd0, w0}, {16'd0, w1});
    tick();

    // Back-to-back with DATA_VALID held high, P=2.
    P_DATA = 8'h11;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    PRESCALE = 6'd2;
    DATA_VALID = 1'b1;
    tick();
    P_DATA = 8'h22;
    for (int k = 1; k < 20; k++) tick();
    check("b2b_stop_last", {30'd0, TX_OUT, BUSY}, 32'd2);
    tick();
    check("b2b_next_start", {30'd0, TX_OUT, BUSY}, 32'd1);
    DATA_VALID = 1'b0;
    for (int k = 0; k < 60 && q.size() > 0; k++) tick();
    check("b2b_drained", q.size(), 0);
    tick();

    // Asynchronous reset in the middle of the data bits.
    P_DATA = 8'h5A;
    PAR_EN = 1'b1;
    PRESCALE = 6'd3;
    DATA_VALID = 1'b1;
    tick();
    DATA_VALID = 1'b0;
    repeat (8) tick();
    check("pre_rst_busy", {31'd0, BUSY}, 32'd1);
    #2 RST = 1'b1;
    #1;
    check("rst_async", {30'd0, TX_OUT, BUSY}, 32'd2);
    chk = 1'b0;
    q.delete();
    tick();
    tick();
    check("rst_hold", {30'd0, TX_OUT, BUSY}, 32'd2);
    RST = 1'b0;
    chk = 1'b1;
    cur_busy = 1'b0;
    run_frame(8'hC3, 1'b1, 1'b1, 6'd2, len);
    check("post_rst_len", len, 22);
    check("post_rst_par", {31'd0, tr_tx[18]}, 32'd1);
    tick();

    // Random traffic against the model.
    for (int k = 0; k < 700; k++) begin
      DATA_VALID = ($urandom_range(0, 3) == 0);
      P_DATA = 8'($urandom);
      PAR_EN = 1'($urandom);
      PAR_TYP = 1'($urandom);
      PRESCALE = 6'($urandom_range(0, 4));
      tick();
    end
    DATA_VALID = 1'b0;
    for (int k = 0; k < 100 && q.size() > 0; k++) tick();
    check("rand_drained", q.size(), 0);
    tick();
    check("final_idle", {30'd0, TX_OUT, BUSY}, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
